pcm_in_sched: RTL and testbench
===============================

PCM_IN_SCHED -- requirements
Module: pcm_in_sched

Interface
REQ-001 The block SHALL have parameter NCH, default 4, the number of requesting channels; the legal value is 4 only, and the channel index is 2 bits.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port REQ, input, 4 bits: per-channel conversion request, level, held high until ACK.
REQ-005 The block SHALL have port CH_S, input, 32 bits: PCM code word of channel i at bits [8i+7:8i].
REQ-006 The block SHALL have port CH_SE, input, 60 bits: 15-bit signal estimate of channel i at bits [15i+14:15i].
REQ-007 The block SHALL have port CH_LAW, input, 4 bits: companding law of channel i (0 = mu-law, 1 = A-law).
REQ-008 The block SHALL have port DP_S, output, 8 bits: code word driven to the shared PCM-decode/subtract datapath.
REQ-009 The block SHALL have port DP_SE, output, 15 bits: signal estimate driven to the datapath.
REQ-010 The block SHALL have port DP_LAW, output, 1 bit: law select driven to the datapath.
REQ-011 The block SHALL have port DP_D, input, 16 bits: difference signal returned by the combinational datapath.
REQ-012 The block SHALL have port ACK, output, 4 bits: one-cycle grant-complete pulse, one-hot.
REQ-013 The block SHALL have port D_OUT, output, 16 bits: registered difference signal of the completed conversion.
REQ-014 The block SHALL have port D_CH, output, 2 bits: channel index belonging to D_OUT.
REQ-015 The block SHALL have port D_VLD, output, 1 bit: one-cycle pulse marking D_OUT/D_CH valid.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, EVAL and DONE; exactly one is active at a time.
REQ-017 In IDLE with REQ != 0, the block SHALL select one channel by round-robin and go to LOAD; with REQ == 0 it SHALL stay in IDLE.
REQ-018 Round-robin SHALL scan from pointer PTR upward modulo 4 (PTR, PTR+1, ... wrapping 3->0) and pick the first set REQ bit.
REQ-019 PTR SHALL update to (granted index + 1) mod 4 on leaving IDLE.
REQ-020 In LOAD, the block SHALL register the granted channel's CH_S, CH_SE and CH_LAW into DP_S, DP_SE and DP_LAW, then go to EVAL.
REQ-021 DP_S, DP_SE and DP_LAW SHALL hold constant from the end of LOAD through DONE, independent of any CH_* change.
REQ-022 In EVAL, the block SHALL capture DP_D into D_OUT and the granted index into D_CH, then go to DONE.
REQ-023 In DONE, the block SHALL assert ACK[granted] and D_VLD for exactly one cycle, then return to IDLE.
REQ-024 Latency SHALL be 3 cycles from the IDLE edge that grants to the edge that makes ACK/D_VLD visible; sustained throughput SHALL be one conversion per 4 cycles.
REQ-025 D_OUT and D_CH SHALL hold their last values until the next EVAL.
REQ-026 A granted channel that drops REQ before ACK SHALL still complete, and its ACK SHALL still pulse.
REQ-027 A channel whose REQ is still high in the IDLE cycle after its ACK SHALL be treated as a new request, subject to round-robin.
REQ-028 Arithmetic SHALL be entirely in the datapath; the block SHALL pass DP_D unmodified, with no truncation or sign change.
REQ-029 The block SHALL never hold more than one conversion in flight, and SHALL ignore REQ changes outside IDLE.

Reset
REQ-030 While RESET is high, the block SHALL force: FSM to IDLE, PTR to 0, ACK to 0, D_VLD to 0, D_OUT to 0, D_CH to 0, DP_S to 0, DP_SE to 0, DP_LAW to 0.
REQ-031 Reset asserted mid-conversion SHALL abort that conversion with no ACK or D_VLD, and the requester SHALL re-request.
REQ-032 After RESET falls, the first grant SHALL be evaluated on the first rising CLK edge.

Verification
REQ-033 The bench SHALL cover single channel: REQ=0001, CH_S[7:0]=8'hFF, SE=0, LAW=0 -> DP_S=8'hFF after LOAD, D_VLD and ACK=0001 on cycle 3, D_CH=0, D_OUT equals DP_D.
REQ-034 The bench SHALL cover round-robin: REQ=1111 held, re-raised after each ACK -> ACK order 0001, 0010, 0100, 1000, 0001, with 4-cycle spacing.
REQ-035 The bench SHALL cover wrap-around: PTR=3 (after granting ch2), REQ=1001 -> ch3 granted first, then ch0.
REQ-036 The bench SHALL cover operand stability: change CH_SE of the granted channel during EVAL -> DP_SE is unchanged and D_OUT reflects the LOAD-time value.
REQ-037 The bench SHALL cover reset mid-conversion: RESET pulsed in EVAL -> all outputs 0, no ACK, next grant from ch0.
REQ-038 The bench SHALL cover dropped request: REQ[2] deasserted in LOAD -> ACK=0100 and D_VLD still pulse in DONE.

Source files
------------

// File: rtl/pcm_in_sched.sv
// Round-robin scheduler that time-shares one PCM-decode/subtract datapath across four channels.
// Each grant runs IDLE -> LOAD -> EVAL -> DONE: operands are frozen, the difference is captured, then ACK/D_VLD pulse.
module pcm_in_sched #(
   parameter int NCH = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NCH-1:0]    req_i,
   input  logic [8*NCH-1:0]  ch_s_i,
   input  logic [15*NCH-1:0] ch_se_i,
   input  logic [NCH-1:0]    ch_law_i,
   output logic [7:0]        dp_s_o,
   output logic [14:0]       dp_se_o,
   output logic              dp_law_o,
   input  logic [15:0]       dp_d_i,
   output logic [NCH-1:0]    ack_o,
   output logic [15:0]       d_out_o,
   output logic [1:0]        d_ch_o,
   output logic              d_vld_o
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      EVAL,
      DONE
   } state_t;

   state_t          state_q;
   logic [1:0]      ptr_q;
   logic [1:0]      grantCh_q;
   logic [7:0]      dpS_q;
   logic [14:0]     dpSe_q;
   logic            dpLaw_q;
   logic [15:0]     dOut_q;
   logic [1:0]      dCh_q;
   logic [NCH-1:0]  ack_q;
   logic            dVld_q;

   logic [1:0]      rrPick_d;
   logic [1:0]      rrIdx;
   logic            rrHit;
   logic [4:0]      sBase;
   logic [5:0]      seBase;

   // Scan upward from the pointer, wrapping 3 -> 0, and keep the first requester found.
   always_comb begin
      rrPick_d = ptr_q;
      rrHit    = 1'b0;
      rrIdx    = ptr_q;
      for (int k = 0; k < 4; k++) begin
         rrIdx = ptr_q + 2'(k);
         if (!rrHit && req_i[rrIdx]) begin
            rrPick_d = rrIdx;
            rrHit    = 1'b1;
         end
      end
   end

   assign sBase  = {grantCh_q, 3'b000};
   assign seBase = 6'(grantCh_q) * 6'd15;

   // ACK and D_VLD default low so they can only ever be single-cycle pulses.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         ptr_q     <= 2'd0;
         grantCh_q <= 2'd0;
         dpS_q     <= 8'd0;
         dpSe_q    <= 15'd0;
         dpLaw_q   <= 1'b0;
         dOut_q    <= 16'd0;
         dCh_q     <= 2'd0;
         ack_q     <= '0;
         dVld_q    <= 1'b0;
      end else begin
         ack_q  <= '0;
         dVld_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (|req_i) begin
                  grantCh_q <= rrPick_d;
                  ptr_q     <= rrPick_d + 2'd1;
                  state_q   <= LOAD;
               end
            end
            LOAD: begin
               dpS_q   <= ch_s_i[sBase +: 8];
               dpSe_q  <= ch_se_i[seBase +: 15];
               dpLaw_q <= ch_law_i[grantCh_q];
               state_q <= EVAL;
            end
            EVAL: begin
               dOut_q  <= dp_d_i;
               dCh_q   <= grantCh_q;
               state_q <= DONE;
            end
            DONE: begin
               ack_q[grantCh_q] <= 1'b1;
               dVld_q           <= 1'b1;
               state_q          <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dp_s_o   = dpS_q;
   assign dp_se_o  = dpSe_q;
   assign dp_law_o = dpLaw_q;
   assign ack_o    = ack_q;
   assign d_out_o  = dOut_q;
   assign d_ch_o   = dCh_q;
   assign d_vld_o  = dVld_q;

endmodule

// File: tb/tb_pcm_in_sched.sv
// Directed bench for pcm_in_sched; a behavioural stub stands in for the shared datapath
// (difference = {law, se} - s), and every expected value below is a hand-computed constant.
module tb_pcm_in_sched;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] chS;
   logic [59:0] chSe;
   logic [3:0]  chLaw;
   logic [7:0]  dpS;
   logic [14:0] dpSe;
   logic        dpLaw;
   logic [15:0] dpD;
   logic [3:0]  ack;
   logic [15:0] dOut;
   logic [1:0]  dCh;
   logic        dVld;

   int checks = 0;
   int fails  = 0;

   pcm_in_sched #(.NCH(4)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .req_i    (req),
      .ch_s_i   (chS),
      .ch_se_i  (chSe),
      .ch_law_i (chLaw),
      .dp_s_o   (dpS),
      .dp_se_o  (dpSe),
      .dp_law_o (dpLaw),
      .dp_d_i   (dpD),
      .ack_o    (ack),
      .d_out_o  (dOut),
      .d_ch_o   (dCh),
      .d_vld_o  (dVld)
   );

   assign dpD = {dpLaw, dpSe} - {8'h00, dpS};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Returns 1 time unit after a rising edge, where outputs are stable.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst   = 1'b1;
      req   = 4'b0000;
      chS   = '0;
      chSe  = '0;
      chLaw = '0;
      tick();
      tick();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      req   = 4'b1111;
      chS   = 32'hDEADBEEF;
      chSe  = {15'h7FFF, 15'h1111, 15'h2222, 15'h3333};
      chLaw = 4'b1111;
      tick();
      tick();
      checks++;
      if (ack !== 4'b0000) begin fails++; $display("[TB] FAIL reset_ack: got %b expected 0000", ack); end
      checks++;
      if (dVld !== 1'b0) begin fails++; $display("[TB] FAIL reset_dvld: got %b expected 0", dVld); end
      checks++;
      if (dOut !== 16'h0000) begin fails++; $display("[TB] FAIL reset_dout: got %h expected 0000", dOut); end
      checks++;
      if (dCh !== 2'd0) begin fails++; $display("[TB] FAIL reset_dch: got %0d expected 0", dCh); end
      checks++;
      if ({dpS, dpSe, dpLaw} !== 24'h0) begin fails++; $display("[TB] FAIL reset_dp: got s=%h se=%h law=%b expected zeros", dpS, dpSe, dpLaw); end
   endtask

   task automatic test_single();
      doReset();
      req   = 4'b0001;
      chS   = 32'h332211FF;
      chSe  = {15'h7003, 15'h6002, 15'h5001, 15'h0000};
      chLaw = 4'b1110;
      tick();
      checks++;
      if (dpS !== 8'h00) begin fails++; $display("[TB] FAIL single_dps_early: got %h expected 00", dpS); end
      tick();
      checks++;
      if ({dpS, dpSe, dpLaw} !== {8'hFF, 15'h0000, 1'b0}) begin fails++; $display("[TB] FAIL single_load: got s=%h se=%h law=%b expected FF 0000 0", dpS, dpSe, dpLaw); end
      tick();
      checks++;
      if (dOut !== 16'hFF01 || dCh !== 2'd0) begin fails++; $display("[TB] FAIL single_eval: got dout=%h dch=%0d expected FF01 0", dOut, dCh); end
      checks++;
      if (ack !== 4'b0000 || dVld !== 1'b0) begin fails++; $display("[TB] FAIL single_early_ack: got ack=%b vld=%b expected 0000 0", ack, dVld); end
      tick();
      checks++;
      if (ack !== 4'b0001 || dVld !== 1'b1) begin fails++; $display("[TB] FAIL single_ack: got ack=%b vld=%b expected 0001 1", ack, dVld); end
      checks++;
      if (dOut !== 16'hFF01) begin fails++; $display("[TB] FAIL single_dout_hold: got %h expected FF01", dOut); end
      req = 4'b0000;
      tick();
      checks++;
      if (ack !== 4'b0000 || dVld !== 1'b0 || dOut !== 16'hFF01) begin fails++; $display("[TB] FAIL single_after: got ack=%b vld=%b dout=%h expected 0000 0 FF01", ack, dVld, dOut); end
   endtask

   task automatic test_round_robin();
      logic [3:0] expAck;
      doReset();
      req   = 4'b1111;
      chS   = 32'h44332211;
      chSe  = {15'h0400, 15'h0300, 15'h0200, 15'h0100};
      chLaw = 4'b0000;
      for (int cyc = 0; cyc < 20; cyc++) begin
         tick();
         expAck = (cyc % 4 == 3) ? (4'b0001 << ((cyc / 4) % 4)) : 4'b0000;
         checks++;
         if (ack !== expAck) begin fails++; $display("[TB] FAIL rr_ack cycle %0d: got %b expected %b", cyc, ack, expAck); end
         if (cyc % 4 == 3) begin
            checks++;
            if (dCh !== 2'((cyc / 4) % 4)) begin fails++; $display("[TB] FAIL rr_dch cycle %0d: got %0d expected %0d", cyc, dCh, (cyc / 4) % 4); end
         end
      end
      req = 4'b0000;
   endtask

   task automatic test_wrap();
      doReset();
      req   = 4'b0100;
      chS   = 32'hA3A2A1A0;
      chSe  = {15'h0040, 15'h0030, 15'h0020, 15'h0010};
      chLaw = 4'b0000;
      tick();
      tick();
      tick();
      tick();
      checks++;
      if (ack !== 4'b0100) begin fails++; $display("[TB] FAIL wrap_ack2: got %b expected 0100", ack); end
      req = 4'b1001;
      tick();
      tick();
      checks++;
      if (dpS !== 8'hA3) begin fails++; $display("[TB] FAIL wrap_load3: got %h expected A3", dpS); end
      tick();
      tick();
      checks++;
      if (ack !== 4'b1000 || dCh !== 2'd3) begin fails++; $display("[TB] FAIL wrap_ack3: got ack=%b dch=%0d expected 1000 3", ack, dCh); end
      req = 4'b0001;
      tick();
      tick();
      checks++;
      if (dpS !== 8'hA0) begin fails++; $display("[TB] FAIL wrap_load0: got %h expected A0", dpS); end
      tick();
      tick();
      checks++;
      if (ack !== 4'b0001 || dCh !== 2'd0) begin fails++; $display("[TB] FAIL wrap_ack0: got ack=%b dch=%0d expected 0001 0", ack, dCh); end
      req = 4'b0000;
   endtask

   task automatic test_operand_stability();
      doReset();
      req   = 4'b0010;
      chS   = 32'h00005A00;
      chSe  = {15'h0000, 15'h0000, 15'h1234, 15'h0000};
      chLaw = 4'b0010;
      tick();
      tick();
      checks++;
      if ({dpS, dpSe, dpLaw} !== {8'h5A, 15'h1234, 1'b1}) begin fails++; $display("[TB] FAIL stab_load: got s=%h se=%h law=%b expected 5A 1234 1", dpS, dpSe, dpLaw); end
      chSe  = {4{15'h7FFF}};
      chS   = 32'hFFFFFFFF;
      chLaw = 4'b0000;
      #1;
      checks++;
      if (dpSe !== 15'h1234) begin fails++; $display("[TB] FAIL stab_eval_se: got %h expected 1234", dpSe); end
      tick();
      checks++;
      if (dOut !== 16'h91DA) begin fails++; $display("[TB] FAIL stab_dout: got %h expected 91DA", dOut); end
      tick();
      checks++;
      if (ack !== 4'b0010 || dpSe !== 15'h1234 || dpS !== 8'h5A) begin fails++; $display("[TB] FAIL stab_done: got ack=%b se=%h s=%h expected 0010 1234 5A", ack, dpSe, dpS); end
      req = 4'b0000;
   endtask

   task automatic test_reset_mid();
      doReset();
      req   = 4'b0100;
      chS   = 32'h11223344;
      chSe  = {15'h0000, 15'h0200, 15'h0000, 15'h0100};
      chLaw = 4'b0100;
      tick();
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if ({ack, dVld, dOut, dCh} !== 23'h0) begin fails++; $display("[TB] FAIL midrst_out: got ack=%b vld=%b dout=%h dch=%0d expected zeros", ack, dVld, dOut, dCh); end
      checks++;
      if ({dpS, dpSe, dpLaw} !== 24'h0) begin fails++; $display("[TB] FAIL midrst_dp: got s=%h se=%h law=%b expected zeros", dpS, dpSe, dpLaw); end
      req = 4'b0101;
      @(negedge clk);
      rst = 1'b0;
      for (int cyc = 0; cyc < 3; cyc++) begin
         tick();
         checks++;
         if (ack !== 4'b0000 || dVld !== 1'b0) begin fails++; $display("[TB] FAIL midrst_noack cycle %0d: got ack=%b vld=%b expected 0000 0", cyc, ack, dVld); end
      end
      tick();
      checks++;
      if (ack !== 4'b0001 || dCh !== 2'd0 || dOut !== 16'h00BC) begin fails++; $display("[TB] FAIL midrst_regrant: got ack=%b dch=%0d dout=%h expected 0001 0 00BC", ack, dCh, dOut); end
      req = 4'b0000;
   endtask

   task automatic test_dropped_req();
      doReset();
      req   = 4'b0100;
      chS   = 32'h00C30000;
      chSe  = {15'h0000, 15'h0010, 15'h0000, 15'h0000};
      chLaw = 4'b0000;
      tick();
      req = 4'b0000;
      tick();
      checks++;
      if (dpS !== 8'hC3) begin fails++; $display("[TB] FAIL drop_load: got %h expected C3", dpS); end
      tick();
      checks++;
      if (dOut !== 16'hFF4D) begin fails++; $display("[TB] FAIL drop_dout: got %h expected FF4D", dOut); end
      tick();
      checks++;
      if (ack !== 4'b0100 || dVld !== 1'b1 || dCh !== 2'd2) begin fails++; $display("[TB] FAIL drop_ack: got ack=%b vld=%b dch=%0d expected 0100 1 2", ack, dVld, dCh); end
      tick();
      checks++;
      if (ack !== 4'b0000 || dVld !== 1'b0) begin fails++; $display("[TB] FAIL drop_after: got ack=%b vld=%b expected 0000 0", ack, dVld); end
   endtask

   initial begin
      rst   = 1'b1;
      req   = 4'b0000;
      chS   = '0;
      chSe  = '0;
      chLaw = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_operand_stability();
      test_reset_mid();
      test_dropped_req();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
